// File: rtl/key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : key_led_ctrl
// Purpose  : Debounced push-button front end with short/long press pulses
//            steering a four-mode LED pattern generator.
// Revision : 1.0
// ============================================================================
module key_led_ctrl #(
  parameter int NUM_KEYS          = 2,
  parameter int NUM_LEDS          = 4,
  parameter int KEY_ACTIVE_HIGH   = 1,
  parameter int DEBOUNCE_CYCLES   = 8192,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter int TICK_DIV          = 12500000
) (
  input  logic                clk_50m,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] key,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_pulse,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [1:0]          led_mode,
  output logic                paused,
  output logic [NUM_LEDS-1:0] usr_led
);

  localparam int c_DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int c_HOLD_W = $clog2(LONG_PRESS_CYCLES + 2);
  localparam int c_DIV_W  = $clog2(TICK_DIV);

  localparam logic [c_DB_W-1:0]   c_DB_MAX    = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0] c_HOLD_LONG = c_HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [c_DIV_W-1:0]  c_DIV_MAX   = c_DIV_W'(TICK_DIV - 1);
  localparam logic [NUM_KEYS-1:0] c_IDLE      = (KEY_ACTIVE_HIGH != 0) ? '0 : '1;
  localparam logic [NUM_LEDS-1:0] c_SEED_UP   = NUM_LEDS'(1);
  localparam logic [NUM_LEDS-1:0] c_SEED_DN   = NUM_LEDS'(1) << (NUM_LEDS - 1);

  localparam logic [1:0] c_MODE_BLINK  = 2'd0;
  localparam logic [1:0] c_MODE_UP     = 2'd1;
  localparam logic [1:0] c_MODE_DN     = 2'd2;

  // Synchronisers reset to the idle pin level so reset never looks like a press.
  logic [NUM_KEYS-1:0] sync1_q, sync2_q, pressed;

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= c_IDLE;
      sync2_q <= c_IDLE;
    end else begin
      sync1_q <= key;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ c_IDLE;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    logic [c_DB_W-1:0]   db_cnt_q;
    logic [c_HOLD_W-1:0] hold_cnt_q;
    logic                state_q, state_dly_q, pulse_q, long_q;

    always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q    <= '0;
        hold_cnt_q  <= '0;
        state_q     <= 1'b0;
        state_dly_q <= 1'b0;
        pulse_q     <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        if (pressed[i] == state_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == c_DB_MAX) begin
          db_cnt_q <= '0;
          state_q  <= pressed[i];
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end

        state_dly_q <= state_q;
        pulse_q     <= state_q & ~state_dly_q;

        // Saturating one past the threshold keeps the long pulse single-shot.
        if (!state_q) begin
          hold_cnt_q <= '0;
        end else if (hold_cnt_q <= c_HOLD_LONG) begin
          hold_cnt_q <= hold_cnt_q + 1'b1;
        end
        long_q <= state_q && (hold_cnt_q == c_HOLD_LONG);
      end
    end

    assign key_state[i] = state_q;
    assign key_pulse[i] = pulse_q;
    assign key_long[i]  = long_q;
  end

  logic [1:0]          mode_q, mode_d;
  logic                paused_q, paused_d, mode_wr;
  logic [c_DIV_W-1:0]  div_q, div_d;
  logic [NUM_LEDS-1:0] pat_q, pat_d, seed;
  logic                tick;

  assign tick = !paused_q && (div_q == c_DIV_MAX);

  always_comb begin
    mode_d   = mode_q;
    paused_d = paused_q;
    mode_wr  = 1'b0;
    if (key_long[0]) begin
      mode_d   = c_MODE_BLINK;
      paused_d = 1'b0;
      mode_wr  = 1'b1;
    end else if (key_long[1]) begin
      paused_d = ~paused_q;
    end else if (key_pulse[0] && key_pulse[1]) begin
      mode_wr  = 1'b0;
    end else if (key_pulse[0]) begin
      mode_d   = mode_q + 2'd1;
      mode_wr  = 1'b1;
    end else if (key_pulse[1]) begin
      mode_d   = mode_q - 2'd1;
      mode_wr  = 1'b1;
    end
  end

  // A mode write restarts the pattern from its seed and drops any same-cycle tick.
  always_comb begin
    case (mode_d)
      c_MODE_UP: seed = c_SEED_UP;
      c_MODE_DN: seed = c_SEED_DN;
      default:   seed = '0;
    endcase
    div_d = div_q;
    pat_d = pat_q;
    if (mode_wr) begin
      div_d = '0;
      pat_d = seed;
    end else if (!paused_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        case (mode_q)
          c_MODE_BLINK: pat_d = ~pat_q;
          c_MODE_UP:    pat_d = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
          c_MODE_DN:    pat_d = {pat_q[0], pat_q[NUM_LEDS-1:1]};
          default:      pat_d = pat_q + 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      paused_q <= 1'b0;
      div_q    <= '0;
      pat_q    <= '0;
    end else begin
      mode_q   <= mode_d;
      paused_q <= paused_d;
      div_q    <= div_d;
      pat_q    <= pat_d;
    end
  end

  assign led_mode = mode_q;
  assign paused   = paused_q;
  assign usr_led  = pat_q;

endmodule
`default_nettype wire

// File: tb/tb_key_led_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_led_ctrl
// Purpose  : Directed self-checking bench for key_led_ctrl (D=4, L=20, TICK=3).
// Revision : 1.0
// ============================================================================
module tb_key_led_ctrl;

  logic       clk_50m = 1'b0;
  logic       rst_n   = 1'b0;
  logic [1:0] key     = 2'b00;
  logic [1:0] key_state, key_pulse, key_long, led_mode;
  logic       paused;
  logic [3:0] usr_led;
  logic [12:0] all_out;

  int n_vec = 0;
  int n_err = 0;

  key_led_ctrl #(
    .NUM_KEYS(2), .NUM_LEDS(4), .KEY_ACTIVE_HIGH(1),
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(20), .TICK_DIV(3)
  ) dut (
    .clk_50m  (clk_50m),
    .rst_n    (rst_n),
    .key      (key),
    .key_state(key_state),
    .key_pulse(key_pulse),
    .key_long (key_long),
    .led_mode (led_mode),
    .paused   (paused),
    .usr_led  (usr_led)
  );

  assign all_out = {key_state, key_pulse, key_long, led_mode, paused, usr_led};

  always #5 clk_50m = ~clk_50m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk_50m);
  endtask

  task automatic press_release(input int idx, input int hold);
    key[idx] = 1'b1;
    repeat (hold) step();
    key[idx] = 1'b0;
    repeat (15) step();
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst_n = 1'b0;
    key   = 2'b00;
    repeat (3) step();
    n_vec++;
    if (all_out !== 13'd0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0000", all_out);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      exp = (((k / 3) % 2) == 1) ? 4'hF : 4'h0;
      n_vec++;
      if (usr_led !== exp || key_pulse !== 2'b00 || key_long !== 2'b00 || led_mode !== 2'd0) begin
        n_err++;
        $display("FAIL blink_k%0d: led=%b pulse=%b long=%b mode=%0d want led=%b others 0",
                 k, usr_led, key_pulse, key_long, led_mode, exp);
      end
    end
  endtask

  task automatic test_bounce();
    int pcnt;
    int lcnt;
    logic [3:0] exp;
    pcnt = 0;
    lcnt = 0;
    key[0] = 1'b1; step(); step();
    key[0] = 1'b0; step();
    key[0] = 1'b1;
    for (int k = 1; k <= 35; k++) begin
      step();
      if (key_pulse[0]) pcnt++;
      if (key_long != 2'b00) lcnt++;
      if (k == 6) begin
        n_vec++;
        if (key_state !== 2'b01) begin
          n_err++; $display("FAIL bounce_state: got %b want 01", key_state);
        end
      end
      if (k == 7) begin
        n_vec++;
        if (key_pulse !== 2'b01) begin
          n_err++; $display("FAIL bounce_pulse: got %b want 01", key_pulse);
        end
      end
      if (k >= 8 && k <= 20) begin
        exp = 4'b0001 << (((k - 8) / 3) % 4);
        n_vec++;
        if (usr_led !== exp || led_mode !== 2'd1) begin
          n_err++; $display("FAIL chase_up_k%0d: led=%b mode=%0d want led=%b mode=1",
                            k, usr_led, led_mode, exp);
        end
      end
      if (k == 20) key[0] = 1'b0;
    end
    n_vec++;
    if (pcnt != 1 || lcnt != 0 || led_mode !== 2'd1) begin
      n_err++; $display("FAIL bounce_counts: pulses=%0d longs=%0d mode=%0d want 1/0/1",
                        pcnt, lcnt, led_mode);
    end
  endtask

  task automatic test_binary();
    logic [3:0] exp;
    press_release(1, 10);
    n_vec++;
    if (led_mode !== 2'd0) begin
      n_err++; $display("FAIL dec_to_0: mode=%0d want 0", led_mode);
    end
    key[1] = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      step();
      if (k == 7) begin
        n_vec++;
        if (key_pulse !== 2'b10) begin
          n_err++; $display("FAIL bin_pulse: got %b want 10", key_pulse);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (led_mode !== 2'd3) begin
          n_err++; $display("FAIL bin_mode: got %0d want 3", led_mode);
        end
      end
      if (k >= 8 && ((k - 8) % 3) == 0) begin
        exp = 4'(((k - 8) / 3) % 16);
        n_vec++;
        if (usr_led !== exp) begin
          n_err++; $display("FAIL bin_k%0d: led=%b want %b", k, usr_led, exp);
        end
      end
      if (k == 10) key[1] = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    key = 2'b11;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 7) begin
        n_vec++;
        if (key_pulse !== 2'b11) begin
          n_err++; $display("FAIL simul_pulse: got %b want 11", key_pulse);
        end
      end
      if (k == 8 || k == 20) begin
        n_vec++;
        if (led_mode !== 2'd3) begin
          n_err++; $display("FAIL simul_mode_k%0d: got %0d want 3", k, led_mode);
        end
      end
      if (k == 10) key = 2'b00;
    end
  endtask

  task automatic test_long_pause();
    int lcnt;
    logic [3:0] exp;
    lcnt = 0;
    key[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (key_long[1]) lcnt++;
      if (k == 8) begin
        n_vec++;
        if (led_mode !== 2'd2) begin
          n_err++; $display("FAIL pause_mode: got %0d want 2", led_mode);
        end
      end
      if (k == 27) begin
        n_vec++;
        if (key_long !== 2'b10) begin
          n_err++; $display("FAIL long1: got %b want 10", key_long);
        end
      end
      if (k == 28) begin
        n_vec++;
        if (paused !== 1'b1) begin
          n_err++; $display("FAIL paused_set: got %b want 1", paused);
        end
      end
      if (k >= 8) begin
        exp = (k <= 28) ? (4'b1000 >> (((k - 8) / 3) % 4)) : 4'b0010;
        n_vec++;
        if (usr_led !== exp) begin
          n_err++; $display("FAIL pause_led_k%0d: led=%b want %b", k, usr_led, exp);
        end
      end
      if (k == 30) key[1] = 1'b0;
    end
    n_vec++;
    if (lcnt != 1) begin
      n_err++; $display("FAIL long1_count: got %0d want 1", lcnt);
    end

    key[1] = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 8) begin
        n_vec++;
        if (led_mode !== 2'd1 || paused !== 1'b1) begin
          n_err++; $display("FAIL resume_mode: mode=%0d paused=%b want 1/1", led_mode, paused);
        end
      end
      if (k == 28) begin
        n_vec++;
        if (paused !== 1'b0) begin
          n_err++; $display("FAIL paused_clr: got %b want 0", paused);
        end
      end
      if (k >= 8) begin
        exp = (k <= 30) ? 4'b0001 : (4'b0001 << ((((k - 31) / 3) + 1) % 4));
        n_vec++;
        if (usr_led !== exp) begin
          n_err++; $display("FAIL resume_led_k%0d: led=%b want %b", k, usr_led, exp);
        end
      end
      if (k == 30) key[1] = 1'b0;
    end
  endtask

  task automatic test_long_reset();
    int lcnt;
    int early;
    lcnt  = 0;
    early = 0;
    press_release(0, 10);
    press_release(0, 10);
    press_release(1, 30);
    n_vec++;
    if (led_mode !== 2'd2 || paused !== 1'b1) begin
      n_err++; $display("FAIL setup_m2p: mode=%0d paused=%b want 2/1", led_mode, paused);
    end
    key[0] = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      step();
      if (key_long[0]) lcnt++;
      if (k == 7) begin
        n_vec++;
        if (key_pulse !== 2'b01) begin
          n_err++; $display("FAIL lr_pulse: got %b want 01", key_pulse);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (led_mode !== 2'd3 || paused !== 1'b1 || usr_led !== 4'b0000) begin
          n_err++; $display("FAIL lr_m3: mode=%0d paused=%b led=%b want 3/1/0000",
                            led_mode, paused, usr_led);
        end
      end
      if (k == 27) begin
        n_vec++;
        if (key_long !== 2'b01) begin
          n_err++; $display("FAIL long0: got %b want 01", key_long);
        end
      end
      if (k == 28) begin
        n_vec++;
        if (led_mode !== 2'd0 || paused !== 1'b0 || usr_led !== 4'b0000) begin
          n_err++; $display("FAIL lr_m0: mode=%0d paused=%b led=%b want 0/0/0000",
                            led_mode, paused, usr_led);
        end
      end
      if (k == 31) begin
        n_vec++;
        if (usr_led !== 4'b1111) begin
          n_err++; $display("FAIL lr_blink: led=%b want 1111", usr_led);
        end
      end
    end
    n_vec++;
    if (lcnt != 1) begin
      n_err++; $display("FAIL long0_count: got %0d want 1", lcnt);
    end

    rst_n = 1'b0;
    #1;
    n_vec++;
    if (all_out !== 13'd0) begin
      n_err++; $display("FAIL async_reset: got %h want 0000", all_out);
    end
    step();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k < 7 && key_pulse !== 2'b00) early++;
      if (k == 7) begin
        n_vec++;
        if (key_pulse !== 2'b01) begin
          n_err++; $display("FAIL held_reset_pulse: got %b want 01", key_pulse);
        end
      end
      if (k == 8) begin
        n_vec++;
        if (led_mode !== 2'd1) begin
          n_err++; $display("FAIL held_reset_mode: got %0d want 1", led_mode);
        end
      end
      if (k == 10) key[0] = 1'b0;
    end
    n_vec++;
    if (early != 0) begin
      n_err++; $display("FAIL stale_pulse: got %0d early pulses want 0", early);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_binary();
    test_simultaneous();
    test_long_pause();
    test_long_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
